apb4_timer_mc: RTL and testbench
================================

// Module: apb4_timer_mc
// PURPOSE
//   Multi-channel APB4 timer, successor to the single-channel timer. Each of CH_NUM channels has
//   its own prescaler, counter, compare, up/down direction, periodic/one-shot mode and W1C
//   overflow flag. Prescaling is a clock-enable tick in the single pclk domain (no divided
//   clock). Sits on the APB4 peripheral bus and drives one interrupt line per channel.
// PARAMETERS
//   CH_NUM     4   number of channels, 1..8
//   CNT_WIDTH  32  counter/compare width, 8..32
//   PSCR_WIDTH 16  prescaler width, 1..32
// PORTS
//   apb4.pclk     in   1            clock; all state in this domain
//   apb4.presetn  in   1            asynchronous active-low reset
//   apb4.paddr    in   32           byte address; [7:5] channel, [4:2] register
//   apb4.psel/penable/pwrite in 1   APB4 control
//   apb4.pwdata   in   32           write data
//   apb4.prdata   out  32           read data
//   apb4.pready   out  1            tied 1
//   apb4.pslverr  out  1            error response
//   irq_o         out  CH_NUM       per-channel interrupt, level
// BEHAVIOUR
//   Access: wr = psel&penable&pwrite, rd = psel&penable&~pwrite. Zero wait states.
//   Map per channel c (base c*0x20): 0x00 CTRL, 0x04 PSCR, 0x08 CMP, 0x0C CNT, 0x10 STAT.
//   CTRL[0] EN, [1] MODE (0 periodic, 1 one-shot), [2] DIR (0 up, 1 down), [3] IE; other bits read 0.
//   STAT[0] OVF, W1C. Register fields narrower than 32 bits zero-extend on read; upper write bits dropped.
//   pslverr=1 during an access phase with channel>=CH_NUM or offset>0x10: write ignored, prdata=0.
//   prdata: combinational, valid only during rd; 0 otherwise.
//   Reset: all CTRL/PSCR/CMP/CNT/STAT and prescaler counters 0; irq_o=0; pslverr=0.
//   Prescaler: psc counts 0..PSCR while EN=1, giving tick on the cycle psc==PSCR, then psc->0.
//     Tick period = PSCR+1 pclk cycles; PSCR=0 ticks every cycle.
//     psc held at 0 while EN=0. psc cleared on a PSCR write and on an EN 0->1 write.
//   Tick, up:   CNT==CMP -> CNT=0, OVF event; else CNT+1.
//   Tick, down: CNT==0   -> CNT=CMP, OVF event; else CNT-1.
//   CMP=0: an OVF event occurs every tick in either direction.
//   CNT>CMP while counting up: CNT counts to all-ones, wraps to 0 with no event, then reaches CMP.
//   One-shot: an OVF event also clears EN the same edge; CNT holds the reloaded value (0 up, CMP down).
//   Effect visible on the edge after the tick (1-cycle latency); OVF is set on the same edge.
//   Priority, same cycle:
//     CNT write beats tick: written value loaded, no increment, no event.
//     CTRL write beats one-shot EN clear.
//     OVF set beats STAT W1C: flag stays 1.
//   irq_o[c] = STAT.OVF & CTRL.IE, from registers only (glitch-free). Clearing IE masks it without clearing OVF.
//   Changing DIR or CMP mid-count takes effect from the next tick; no reload.
//   Reset asserted mid-count returns every channel to the reset state immediately (async).
// TESTING
//   Ch0 PSCR=3, CMP=4, up, periodic, IE=1, EN=1
//     -> CNT steps every 4 cycles 0..4,0; OVF and irq_o[0] rise 20 cycles after EN.
//   Ch1 down, one-shot, CMP=2, PSCR=0, CNT=2, EN=1
//     -> CNT 2,1,0,2; on the reload edge OVF=1 and EN=0; CNT holds 2.
//   Ch2: STAT W1C on the exact cycle of a new OVF event -> OVF reads 1.
//     A later W1C with no event -> 0, irq_o[2] falls the next cycle.
//   CNT write of 0x10 on a tick cycle -> CNT=0x10 next cycle, no increment.
//   Access to channel CH_NUM or offset 0x14 -> pslverr=1, prdata=0, no state change.
//   Counting at full speed; presetn low for 1 cycle mid-run -> all regs 0, irq_o=0, counting stopped.

Source files
------------

// File: rtl/apb4_timer_mc_if.sv
// APB4 bus bundle for the multi-channel timer. Clock and reset travel with
// the bus so that every piece of timer state lives in the pclk domain.
interface apb4_timer_mc_if (
    input logic pclk,
    input logic presetn
);
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        input  pclk, presetn, prdata, pready, pslverr,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        input  pclk, presetn, paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb4_timer_mc.sv
// Multi-channel APB4 timer. Each channel has a clock-enable prescaler, an
// up/down counter with compare, periodic/one-shot mode and a W1C overflow flag
// driving a level interrupt. Register block per channel at c*0x20:
// 0x00 CTRL, 0x04 PSCR, 0x08 CMP, 0x0C CNT, 0x10 STAT.
module apb4_timer_mc #(
    parameter int CH_NUM     = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int PSCR_WIDTH = 16
) (
    apb4_timer_mc_if.slave    apb4,
    output logic [CH_NUM-1:0] irq_o
);
    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_PSCR = 3'd1;
    localparam logic [2:0] REG_CMP  = 3'd2;
    localparam logic [2:0] REG_CNT  = 3'd3;
    localparam logic [2:0] REG_STAT = 3'd4;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PSCR_WIDTH-1:0] PSC_ONE = {{(PSCR_WIDTH-1){1'b0}}, 1'b1};

    // Bus decode
    logic       w_acc, w_wr, w_rd, w_valid;
    logic [2:0] w_ch, w_reg;
    logic       w_unused;

    assign w_acc    = apb4.psel & apb4.penable;
    assign w_wr     = w_acc & apb4.pwrite;
    assign w_rd     = w_acc & ~apb4.pwrite;
    assign w_ch     = apb4.paddr[7:5];
    assign w_reg    = apb4.paddr[4:2];
    assign w_valid  = ({29'd0, w_ch} < 32'(CH_NUM)) && (w_reg <= REG_STAT);
    assign w_unused = ^{apb4.paddr[31:8], apb4.paddr[1:0], apb4.pwdata};

    // Per-channel state
    logic [CH_NUM-1:0]     r_en, r_mode, r_dir, r_ie, r_ovf;
    logic [PSCR_WIDTH-1:0] r_pscr [CH_NUM];
    logic [PSCR_WIDTH-1:0] r_psc  [CH_NUM];
    logic [CNT_WIDTH-1:0]  r_cmp  [CH_NUM];
    logic [CNT_WIDTH-1:0]  r_cnt  [CH_NUM];

    logic [CH_NUM-1:0]     w_wr_ctrl, w_wr_pscr, w_wr_cmp, w_wr_cnt, w_wr_stat;
    logic [CH_NUM-1:0]     w_tick, w_hit, w_evt, w_en_rise;
    logic [CNT_WIDTH-1:0]  w_cnt_tick [CH_NUM];
    logic [31:0]           w_rdata;

    // Write strobes, tick generation and the counter value a tick would produce
    always_comb begin
        w_wr_ctrl = '0;
        w_wr_pscr = '0;
        w_wr_cmp  = '0;
        w_wr_cnt  = '0;
        w_wr_stat = '0;
        w_tick    = '0;
        w_hit     = '0;
        w_evt     = '0;
        w_en_rise = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            w_cnt_tick[c] = r_cnt[c];
        end
        for (int c = 0; c < CH_NUM; c++) begin
            if (w_wr && w_valid && (w_ch == 3'(c))) begin
                w_wr_ctrl[c] = (w_reg == REG_CTRL);
                w_wr_pscr[c] = (w_reg == REG_PSCR);
                w_wr_cmp[c]  = (w_reg == REG_CMP);
                w_wr_cnt[c]  = (w_reg == REG_CNT);
                w_wr_stat[c] = (w_reg == REG_STAT);
            end else begin
                w_wr_ctrl[c] = 1'b0;
            end
            w_en_rise[c] = w_wr_ctrl[c] & apb4.pwdata[0] & ~r_en[c];
            w_tick[c]    = r_en[c] && (r_psc[c] == r_pscr[c]);
            if (r_dir[c]) begin
                // Down: reload from CMP when the counter has reached zero
                if (r_cnt[c] == '0) begin
                    w_cnt_tick[c] = r_cmp[c];
                    w_hit[c]      = 1'b1;
                end else begin
                    w_cnt_tick[c] = r_cnt[c] - CNT_ONE;
                end
            end else begin
                // Up: a counter above CMP simply wraps through all-ones
                if (r_cnt[c] == r_cmp[c]) begin
                    w_cnt_tick[c] = '0;
                    w_hit[c]      = 1'b1;
                end else begin
                    w_cnt_tick[c] = r_cnt[c] + CNT_ONE;
                end
            end
            // A CNT write on the tick cycle wins and suppresses the event
            w_evt[c] = w_tick[c] & w_hit[c] & ~w_wr_cnt[c];
        end
    end

    // Channel registers: prescaler, counter, control, compare and overflow flag
    always_ff @(posedge apb4.pclk or negedge apb4.presetn) begin
        if (!apb4.presetn) begin
            r_en   <= '0;
            r_mode <= '0;
            r_dir  <= '0;
            r_ie   <= '0;
            r_ovf  <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
                r_pscr[c] <= '0;
                r_psc[c]  <= '0;
                r_cmp[c]  <= '0;
                r_cnt[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (w_wr_pscr[c] || w_en_rise[c] || !r_en[c] || w_tick[c]) begin
                    r_psc[c] <= '0;
                end else begin
                    r_psc[c] <= r_psc[c] + PSC_ONE;
                end

                if (w_wr_cnt[c]) begin
                    r_cnt[c] <= apb4.pwdata[CNT_WIDTH-1:0];
                end else if (w_tick[c]) begin
                    r_cnt[c] <= w_cnt_tick[c];
                end else begin
                    r_cnt[c] <= r_cnt[c];
                end

                if (w_wr_pscr[c]) begin
                    r_pscr[c] <= apb4.pwdata[PSCR_WIDTH-1:0];
                end
                if (w_wr_cmp[c]) begin
                    r_cmp[c] <= apb4.pwdata[CNT_WIDTH-1:0];
                end

                // A software CTRL write overrides the one-shot self-disable
                if (w_wr_ctrl[c]) begin
                    r_en[c]   <= apb4.pwdata[0];
                    r_mode[c] <= apb4.pwdata[1];
                    r_dir[c]  <= apb4.pwdata[2];
                    r_ie[c]   <= apb4.pwdata[3];
                end else if (w_evt[c] && r_mode[c]) begin
                    r_en[c] <= 1'b0;
                end

                // A new overflow beats a simultaneous W1C
                if (w_evt[c]) begin
                    r_ovf[c] <= 1'b1;
                end else if (w_wr_stat[c] && apb4.pwdata[0]) begin
                    r_ovf[c] <= 1'b0;
                end
            end
        end
    end

    // Read mux: zero-extended register of the addressed channel
    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            if (w_ch == 3'(c)) begin
                case (w_reg)
                    REG_CTRL: w_rdata = {28'd0, r_ie[c], r_dir[c], r_mode[c], r_en[c]};
                    REG_PSCR: w_rdata = 32'(r_pscr[c]);
                    REG_CMP:  w_rdata = 32'(r_cmp[c]);
                    REG_CNT:  w_rdata = 32'(r_cnt[c]);
                    REG_STAT: w_rdata = {31'd0, r_ovf[c]};
                    default:  w_rdata = 32'd0;
                endcase
            end else begin
                w_rdata = w_rdata;
            end
        end
    end

    assign apb4.prdata  = (w_rd && w_valid) ? w_rdata : 32'd0;
    assign apb4.pready  = 1'b1;
    assign apb4.pslverr = w_acc & ~w_valid;
    assign irq_o        = r_ovf & r_ie;
endmodule

// File: tb/tb_apb4_timer_mc.sv
// Directed self-checking bench for apb4_timer_mc (4 channels, 32-bit counter,
// 16-bit prescaler). Every task drives its own scenario and checks inline.
module tb_apb4_timer_mc;
    logic       clk;
    logic       rst_n;
    logic [3:0] irq;
    int         errors;
    int         checks;

    apb4_timer_mc_if u_if (.pclk(clk), .presetn(rst_n));

    apb4_timer_mc #(.CH_NUM(4), .CNT_WIDTH(32), .PSCR_WIDTH(16)) dut (
        .apb4  (u_if),
        .irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
        u_if.paddr   = addr;
        u_if.pwdata  = data;
        u_if.pwrite  = 1'b1;
        u_if.psel    = 1'b1;
        u_if.penable = 1'b0;
        step();
        u_if.penable = 1'b1;
        #1;
        err = u_if.pslverr;
        step();
        u_if.psel    = 1'b0;
        u_if.penable = 1'b0;
        u_if.pwrite  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic e;
        apb_write(addr, data, e);
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        u_if.paddr   = addr;
        u_if.pwrite  = 1'b0;
        u_if.psel    = 1'b1;
        u_if.penable = 1'b0;
        step();
        u_if.penable = 1'b1;
        #1;
        data = u_if.prdata;
        err  = u_if.pslverr;
        step();
        u_if.psel    = 1'b0;
        u_if.penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        e;
        checks++;
        if (irq !== 4'h0) begin
            errors++;
            $display("FAIL reset_irq: got %h expected 0", irq);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 5; r++) begin
                apb_read(32'(c * 32 + r * 4), d, e);
                checks++;
                if (d !== 32'd0 || e !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_reg ch%0d off%0h: got data %h err %b expected 0/0", c, r * 4, d, e);
                end
            end
        end
        checks++;
        if (u_if.pready !== 1'b1) begin
            errors++;
            $display("FAIL pready: got %b expected 1", u_if.pready);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        logic        e;
        wr(32'h24, 32'hFFFF_FFFF);
        apb_read(32'h24, d, e);
        checks++;
        if (d !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL pscr_width: got %h expected 0000ffff", d);
        end
        wr(32'h20, 32'hFFFF_FFF0);
        apb_read(32'h20, d, e);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL ctrl_upper: got %h expected 0", d);
        end
        wr(32'h28, 32'hA5A5_A5A5);
        apb_read(32'h28, d, e);
        checks++;
        if (d !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL cmp_rw: got %h expected a5a5a5a5", d);
        end
        wr(32'h24, 32'h0);
        wr(32'h28, 32'h0);
    endtask

    task automatic test_ch0_periodic();
        logic [31:0] d;
        logic        e;
        wr(32'h04, 32'd3);
        wr(32'h08, 32'd4);
        wr(32'h00, 32'h9);            // EN | IE, up, periodic; this edge is E0
        for (int k = 0; k < 6; k++) begin
            apb_read(32'h0C, d, e);   // samples state after edge 4k+1
            checks++;
            if (d !== 32'(k % 5)) begin
                errors++;
                $display("FAIL ch0_cnt k=%0d: got %0d expected %0d", k, d, k % 5);
            end
            for (int s = 3; s <= 4; s++) begin
                step();
                checks++;
                if (irq[0] !== ((4 * k + s) >= 20)) begin
                    errors++;
                    $display("FAIL ch0_irq edge %0d: got %b expected %b", 4 * k + s, irq[0], (4 * k + s) >= 20);
                end
            end
        end
        apb_read(32'h10, d, e);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL ch0_ovf: got %h expected 1", d);
        end
        wr(32'h00, 32'h0);
        wr(32'h10, 32'h1);
    endtask

    task automatic test_ch1_oneshot();
        logic [31:0] d;
        logic        e;
        wr(32'h28, 32'd2);
        wr(32'h2C, 32'd2);
        wr(32'h20, 32'hF);            // EN | ONE-SHOT | DOWN | IE; edge E0
        apb_read(32'h2C, d, e);       // edge E1
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL ch1_cnt_e1: got %0d expected 1", d);
        end
        checks++;
        if (irq[1] !== 1'b0) begin    // after E2, CNT=0
            errors++;
            $display("FAIL ch1_irq_e2: got %b expected 0", irq[1]);
        end
        step();                       // E3: reload, OVF, EN cleared
        checks++;
        if (irq[1] !== 1'b1) begin
            errors++;
            $display("FAIL ch1_irq_e3: got %b expected 1", irq[1]);
        end
        apb_read(32'h2C, d, e);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL ch1_cnt_hold: got %0d expected 2", d);
        end
        apb_read(32'h20, d, e);
        checks++;
        if (d !== 32'hE) begin
            errors++;
            $display("FAIL ch1_ctrl: got %h expected e", d);
        end
        apb_read(32'h30, d, e);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL ch1_ovf: got %h expected 1", d);
        end
        wr(32'h30, 32'h1);
        wr(32'h20, 32'h0);
        checks++;
        if (irq[1] !== 1'b0) begin
            errors++;
            $display("FAIL ch1_irq_clr: got %b expected 0", irq[1]);
        end
    endtask

    task automatic test_ch2_w1c();
        logic [31:0] d;
        logic        e;
        wr(32'h48, 32'd3);
        wr(32'h40, 32'h9);            // edge E0; event due on E4
        step();
        step();
        wr(32'h50, 32'h1);            // W1C lands exactly on E4
        apb_read(32'h50, d, e);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL ch2_w1c_race: got %h expected 1", d);
        end
        wr(32'h40, 32'h0);            // IE off masks irq, OVF stays
        checks++;
        if (irq[2] !== 1'b0) begin
            errors++;
            $display("FAIL ch2_mask: got %b expected 0", irq[2]);
        end
        apb_read(32'h50, d, e);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL ch2_mask_ovf: got %h expected 1", d);
        end
        wr(32'h40, 32'h8);
        // W1C with no event pending: irq drops on the write edge
        u_if.paddr   = 32'h50;
        u_if.pwdata  = 32'h1;
        u_if.pwrite  = 1'b1;
        u_if.psel    = 1'b1;
        u_if.penable = 1'b0;
        step();
        u_if.penable = 1'b1;
        #1;
        checks++;
        if (irq[2] !== 1'b1) begin
            errors++;
            $display("FAIL ch2_irq_before: got %b expected 1", irq[2]);
        end
        step();
        u_if.psel    = 1'b0;
        u_if.penable = 1'b0;
        u_if.pwrite  = 1'b0;
        checks++;
        if (irq[2] !== 1'b0) begin
            errors++;
            $display("FAIL ch2_irq_after: got %b expected 0", irq[2]);
        end
        apb_read(32'h50, d, e);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL ch2_ovf_clr: got %h expected 0", d);
        end
        wr(32'h40, 32'h0);
    endtask

    task automatic test_cnt_write_tick();
        logic [31:0] d;
        logic        e;
        logic [31:0] exp_cnt [3];
        exp_cnt[0] = 32'h10;
        exp_cnt[1] = 32'h10;
        exp_cnt[2] = 32'h11;
        wr(32'h64, 32'd3);
        wr(32'h68, 32'hFF);
        wr(32'h60, 32'h1);            // edge E0; ticks on E4, E8, E12
        for (int s = 0; s < 6; s++) step();
        wr(32'h6C, 32'h10);           // lands on tick edge E8
        for (int k = 0; k < 3; k++) begin
            apb_read(32'h6C, d, e);   // edges E9, E11, E13
            checks++;
            if (d !== exp_cnt[k]) begin
                errors++;
                $display("FAIL cnt_wr_tick k=%0d: got %h expected %h", k, d, exp_cnt[k]);
            end
        end
        apb_read(32'h70, d, e);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL cnt_wr_no_evt: got %h expected 0", d);
        end
        wr(32'h60, 32'h0);
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic        e;
        apb_write(32'h14, 32'hFFFF_FFFF, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL err_wr_off: got %b expected 1", e);
        end
        apb_write(32'h84, 32'hAB, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL err_wr_ch: got %b expected 1", e);
        end
        apb_read(32'h14, d, e);
        checks++;
        if (e !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL err_rd_off: got err %b data %h expected 1/0", e, d);
        end
        apb_read(32'h80, d, e);
        checks++;
        if (e !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL err_rd_ch: got err %b data %h expected 1/0", e, d);
        end
        apb_read(32'h04, d, e);
        checks++;
        if (e !== 1'b0 || d !== 32'd3) begin
            errors++;
            $display("FAIL err_no_change_pscr: got err %b data %h expected 0/3", e, d);
        end
        apb_read(32'h08, d, e);
        checks++;
        if (d !== 32'd4) begin
            errors++;
            $display("FAIL err_no_change_cmp: got %h expected 4", d);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic        e;
        wr(32'h04, 32'd0);
        wr(32'h08, 32'd5);
        wr(32'h00, 32'h9);
        for (int s = 0; s < 10; s++) step();
        checks++;
        if (irq[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_irq: got %b expected 1", irq[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (irq !== 4'h0) begin
            errors++;
            $display("FAIL rst_async_irq: got %h expected 0", irq);
        end
        step();
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) step();
        for (int r = 0; r < 5; r++) begin
            apb_read(32'(r * 4), d, e);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL rst_reg off%0h: got %h expected 0", r * 4, d);
            end
        end
        apb_read(32'h0C, d, e);
        checks++;
        if (d !== 32'd0 || irq !== 4'h0) begin
            errors++;
            $display("FAIL rst_stopped: got cnt %h irq %h expected 0/0", d, irq);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        u_if.paddr   = 32'h0;
        u_if.pwdata  = 32'h0;
        u_if.psel    = 1'b0;
        u_if.penable = 1'b0;
        u_if.pwrite  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_regs();
        test_ch0_periodic();
        test_ch1_oneshot();
        test_ch2_w1c();
        test_cnt_write_tick();
        test_errors();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
